// File: rtl/mealy_step_fsm.sv
// Push-button stepped Mealy FSM: synchronised, optionally debounced button edge advances state.
// Define MEALY_STEP_FSM_DEBOUNCE_EN to insert the DEB_CYCLES debounce filter after the synchroniser.
module mealy_step_fsm #(
  parameter int NUM_STATES = 4,
  parameter int DEB_CYCLES = 16,
  parameter int CNT_W      = 8,
  localparam int STATE_W   = ($clog2(NUM_STATES) < 1) ? 1 : $clog2(NUM_STATES)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               button,
  input  logic [1:0]         sw,
  output logic [STATE_W-1:0] state,
  output logic [1:0]         led,
  output logic               step,
  output logic [CNT_W-1:0]   step_count
);

  localparam logic [STATE_W:0]   NUM_S = (STATE_W + 1)'(NUM_STATES);
  localparam logic [STATE_W-1:0] LAST  = STATE_W'(NUM_STATES - 1);

  logic               sync1_q, sync2_q;
  logic               deb_level;
  logic               deb_prev_q;
  logic               trigger;
  logic [STATE_W-1:0] state_q, state_d;
  logic [STATE_W-1:0] next_state;
  logic               state_invalid;
  logic [1:0]         led_q, led_d;
  logic               step_q, step_d;
  logic [CNT_W-1:0]   step_count_q, step_count_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= button;
      sync2_q <= sync1_q;
    end
  end

`ifdef MEALY_STEP_FSM_DEBOUNCE_EN
  localparam int DEB_W = ($clog2(DEB_CYCLES) < 1) ? 1 : $clog2(DEB_CYCLES);

  logic             deb_level_q, deb_level_d;
  logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;

  // Count consecutive disagreeing cycles; flip the level on the DEB_CYCLES-th one.
  always_comb begin
    deb_level_d = deb_level_q;
    deb_cnt_d   = '0;
    if (sync2_q != deb_level_q) begin
      if (deb_cnt_q == DEB_W'(DEB_CYCLES - 1)) begin
        deb_level_d = ~deb_level_q;
      end else begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      deb_level_q <= 1'b0;
      deb_cnt_q   <= '0;
    end else begin
      deb_level_q <= deb_level_d;
      deb_cnt_q   <= deb_cnt_d;
    end
  end

  assign deb_level = deb_level_q;
`else
  assign deb_level = sync2_q;
`endif

  assign trigger       = deb_level & ~deb_prev_q;
  assign state_invalid = ({1'b0, state_q} >= NUM_S);

  always_comb begin
    next_state = '0;
    if (state_invalid) begin
      next_state = '0;
    end else if (state_q == '0) begin
      next_state = STATE_W'(1);
    end else if (state_q == LAST) begin
      next_state = sw[1] ? state_q : '0;
    end else if (sw[0]) begin
      next_state = state_q + 1'b1;
    end else begin
      next_state = state_q - 1'b1;
    end
  end

  // Illegal encodings recover to 0 silently; a legal hold transition still pulses step.
  always_comb begin
    state_d      = state_q;
    step_d       = 1'b0;
    step_count_d = step_count_q;
    led_d        = {next_state > state_q, next_state != state_q};
    if (state_invalid) begin
      state_d = '0;
    end else if (trigger) begin
      state_d = next_state;
      step_d  = 1'b1;
      if (step_count_q != {CNT_W{1'b1}}) begin
        step_count_d = step_count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      deb_prev_q   <= 1'b0;
      state_q      <= '0;
      led_q        <= 2'b00;
      step_q       <= 1'b0;
      step_count_q <= '0;
    end else begin
      deb_prev_q   <= deb_level;
      state_q      <= state_d;
      led_q        <= led_d;
      step_q       <= step_d;
      step_count_q <= step_count_d;
    end
  end

  assign state      = state_q;
  assign led        = led_q;
  assign step       = step_q;
  assign step_count = step_count_q;

endmodule

// File: tb/tb_mealy_step_fsm.sv
// Randomised press/bounce stimulus; expected step events queued and checked by an independent monitor.
`timescale 1ns/1ps
module tb_mealy_step_fsm;
  localparam int N   = 5;
  localparam int DEB = 6;
  localparam int CW  = 3;
  localparam int SW_W = ($clog2(N) < 1) ? 1 : $clog2(N);
`ifdef MEALY_STEP_FSM_DEBOUNCE_EN
  localparam int LAT    = 2 + DEB + 1;
  localparam bit DEB_ON = 1'b1;
`else
  localparam int LAT    = 3;
  localparam bit DEB_ON = 1'b0;
`endif
  localparam int CMAX = (1 << CW) - 1;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            button = 1'b0;
  logic [1:0]      sw = 2'b00;
  logic [SW_W-1:0] state;
  logic [1:0]      led;
  logic            step;
  logic [CW-1:0]   step_count;

  mealy_step_fsm #(.NUM_STATES(N), .DEB_CYCLES(DEB), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .button(button), .sw(sw),
    .state(state), .led(led), .step(step), .step_count(step_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int st; int cnt; int at; logic [1:0] swv; } exp_t;
  exp_t exp_q[$];
  int   model_state = 0;
  int   model_cnt   = 0;
  int   checks = 0;
  int   errors = 0;

  function automatic int next_of(int s, logic [1:0] swv);
    if (s == 0) return 1;
    if (s == N - 1) return swv[1] ? s : 0;
    return swv[0] ? s + 1 : s - 1;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // Monitor: consumes one queued expectation per observed step pulse.
  bit         led_pending = 1'b0;
  logic [1:0] led_exp;
  initial begin
    exp_t e;
    int   ns;
    forever begin
      @(negedge clk);
      if (led_pending) begin
        chk("led_after_step", 32'(led), 32'(led_exp));
        chk("step_single_pulse", 32'(step), 32'd0);
        led_pending = 1'b0;
      end
      if (step === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_step", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("state", 32'(state), 32'(e.st));
          chk("step_count", 32'(step_count), 32'(e.cnt));
          chk("step_cycle", 32'(cyc), 32'(e.at));
          ns = next_of(e.st, e.swv);
          led_exp = {ns > e.st, ns != e.st};
          led_pending = 1'b1;
          $display("step: state=%0d count=%0d cycle=%0d sw=%b", state, step_count, cyc, e.swv);
        end
      end
    end
  end

  task automatic expect_step(int rise);
    exp_t e;
    model_state = next_of(model_state, sw);
    model_cnt   = (model_cnt < CMAX) ? model_cnt + 1 : CMAX;
    e.st = model_state; e.cnt = model_cnt; e.at = rise + LAT; e.swv = sw;
    exp_q.push_back(e);
  endtask

  task automatic do_press(int hold, bit bounce);
    int nb;
    sw = 2'($urandom_range(0, 3));
    repeat (3) @(negedge clk);
    if (DEB_ON && bounce) begin
      nb = 1 + int'($urandom_range(0, 3));
      for (int k = 0; k < nb; k++) begin
        button = 1'b1;
        repeat ($urandom_range(1, DEB - 1)) @(negedge clk);
        button = 1'b0;
        repeat ($urandom_range(1, DEB - 1)) @(negedge clk);
      end
    end
    button = 1'b1;
    expect_step(cyc);
    repeat (hold) @(negedge clk);
    button = 1'b0;
    repeat (DEB + 6) @(negedge clk);
  endtask

  // Reset sampled at edge (rise + offset); the still-held button must re-trigger afterwards.
  task automatic press_reset(int offset);
    sw = 2'($urandom_range(0, 3));
    repeat (3) @(negedge clk);
    button = 1'b1;
    repeat (offset - 1) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_step", 32'(step), 32'd0);
    chk("rst_count", 32'(step_count), 32'd0);
    chk("rst_led", 32'(led), 32'd0);
    rst = 1'b0;
    exp_q.delete();
    model_state = 0;
    model_cnt   = 0;
    expect_step(cyc);
    repeat (LAT + 4) @(negedge clk);
    button = 1'b0;
    repeat (DEB + 6) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_led", 32'(led), 32'd0);
    chk("reset_step", 32'(step), 32'd0);
    chk("reset_count", 32'(step_count), 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 10; i++) do_press(LAT + 2 + int'($urandom_range(0, 30)), 1'($urandom_range(0, 1)));
    do_press(1000, 1'b0);
    do_press(LAT + 5, 1'b1);
    press_reset(LAT);
    press_reset(LAT / 2 + 1);
    for (int i = 0; i < 10; i++) do_press(LAT + 2 + int'($urandom_range(0, 20)), 1'($urandom_range(0, 1)));

    repeat (5) @(negedge clk);
    chk("pending_steps", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
